camera_frame_tracker: RTL

//  Sits directly downstream of the camera byte-pairing stage. It consumes 16-bit pixel

---
 rtl/camera_frame_tracker_if.sv | 37 +++
 rtl/camera_frame_tracker.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/camera_frame_tracker_if.sv
// Pixel-stream bundle between the camera pairing stage, the frame tracker and the frame-buffer writer.
// The master drives raw pixels and syncs. The slave returns tagged pixels and frame status.
interface camera_frame_tracker_if #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
);
  localparam int HW = $clog2(H_ACTIVE);
  localparam int VW = $clog2(V_ACTIVE);
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE);

  logic          valid_in;
  logic [15:0]   data_in;
  logic          hs_in;
  logic          vs_in;

  logic          valid_out;
  logic [15:0]   pixel_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic [AW-1:0] addr_out;
  logic          frame_start_out;
  logic          frame_done_out;
  logic          frame_ok_out;
  logic          line_err_out;

  modport master (
    output valid_in, data_in, hs_in, vs_in,
    input  valid_out, pixel_out, hcount_out, vcount_out, addr_out,
           frame_start_out, frame_done_out, frame_ok_out, line_err_out
  );

  modport slave (
    input  valid_in, data_in, hs_in, vs_in,
    output valid_out, pixel_out, hcount_out, vcount_out, addr_out,
           frame_start_out, frame_done_out, frame_ok_out, line_err_out
  );
endinterface

// File: rtl/camera_frame_tracker.sv
// Tags camera pixels with (h, v) position and a linear frame-buffer address.
// Also reports frame boundaries and checks line and frame geometry.
module camera_frame_tracker #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input logic                   clk_pixel_in,
  input logic                   rst_n_in,
  camera_frame_tracker_if.slave bus
);
  localparam int HW  = $clog2(H_ACTIVE);
  localparam int VW  = $clog2(V_ACTIVE);
  localparam int AW  = $clog2(H_ACTIVE * V_ACTIVE);
  // Internal counters need one more value than the output ports so they can reach H_ACTIVE / V_ACTIVE.
  localparam int HCW = $clog2(H_ACTIVE + 1);
  localparam int VCW = $clog2(V_ACTIVE + 1);

  localparam logic [HCW-1:0] H_LIM  = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_LIM  = VCW'(V_ACTIVE);
  localparam logic [AW-1:0]  H_STEP = AW'(H_ACTIVE);

  typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

  state_t         state, state_next;
  logic           hs_prev, vs_prev;
  logic [HCW-1:0] hcount;
  logic [VCW-1:0] vcount;
  logic [AW-1:0]  row_base;

  logic           hs_fall, vs_rise, vs_fall;
  logic           pix_ok, pix_err, line_close;
  logic [HCW-1:0] h_pix, h_after;
  logic [VCW-1:0] v_after;
  logic [AW-1:0]  rb_after;
  logic           err_after, geom_ok;
  logic           start_pulse, done_pulse;

  assign hs_fall = hs_prev & ~bus.hs_in;
  assign vs_rise = ~vs_prev & bus.vs_in;
  assign vs_fall = vs_prev & ~bus.vs_in;

  // Resolve one cycle's events in order: the pixel first, then the line close, then the frame close.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    pix_ok     = 1'b0;
    pix_err    = 1'b0;
    h_pix      = hcount;
    line_close = 1'b0;
    h_after    = hcount;
    v_after    = vcount;
    rb_after   = row_base;
    err_after  = bus.line_err_out;
    geom_ok    = 1'b0;

    pix_ok  = bus.valid_in && (hcount < H_LIM) && (vcount < V_LIM);
    pix_err = bus.valid_in && !pix_ok;
    if (pix_ok) h_pix = hcount + HCW'(1);
    if (pix_err) err_after = 1'b1;

    line_close = hs_fall && (h_pix != '0);
    h_after    = h_pix;
    if (line_close) begin
      h_after = '0;
      if (h_pix != H_LIM) err_after = 1'b1;
      // Row base advances by addition; vcount holds at V_ACTIVE so excess rows cannot wrap it.
      if (vcount != V_LIM) begin
        v_after  = vcount + VCW'(1);
        rb_after = row_base + H_STEP;
      end
    end

    // A line still open at the frame close counts as an error.
    geom_ok = !err_after && (h_after == '0) && (v_after == V_LIM);
  end

  always_comb begin
    state_next  = state;
    start_pulse = 1'b0;
    done_pulse  = 1'b0;
    case (state)
      SYNC:    if (!bus.vs_in) state_next = IDLE;
      IDLE:    if (vs_rise) begin
                 state_next  = FRAME;
                 start_pulse = 1'b1;
               end
      FRAME:   if (vs_fall) begin
                 state_next = IDLE;
                 done_pulse = 1'b1;
               end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= SYNC;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_next;
      hs_prev <= bus.hs_in;
      vs_prev <= bus.vs_in;
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount              <= '0;
      vcount              <= '0;
      row_base            <= '0;
      bus.valid_out       <= 1'b0;
      bus.pixel_out       <= '0;
      bus.hcount_out      <= '0;
      bus.vcount_out      <= '0;
      bus.addr_out        <= '0;
      bus.frame_start_out <= 1'b0;
      bus.frame_done_out  <= 1'b0;
      bus.frame_ok_out    <= 1'b0;
      bus.line_err_out    <= 1'b0;
    end else begin
      bus.valid_out       <= 1'b0;
      bus.frame_start_out <= start_pulse;
      bus.frame_done_out  <= done_pulse;
      bus.frame_ok_out    <= done_pulse && geom_ok;

      if (start_pulse) begin
        hcount           <= '0;
        vcount           <= '0;
        row_base         <= '0;
        bus.line_err_out <= 1'b0;
      end else if (state == FRAME) begin
        bus.valid_out <= pix_ok;
        if (pix_ok) begin
          bus.pixel_out  <= bus.data_in;
          bus.hcount_out <= HW'(hcount);
          bus.vcount_out <= VW'(vcount);
          bus.addr_out   <= row_base + AW'(hcount);
        end
        hcount           <= h_after;
        vcount           <= v_after;
        row_base         <= rb_after;
        bus.line_err_out <= err_after;
      end
    end
  end
endmodule
